// File: rtl/imem_loader_if.sv
// Byte-stream handshake and instruction-memory write bus for imem_loader.
// master: stream source / memory side; slave: the loader.
interface imem_loader_if;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;

  modport master (output byte_valid, byte_data,
                  input  byte_ready, wr_en, wr_addr, wr_data);
  modport slave  (input  byte_valid, byte_data,
                  output byte_ready, wr_en, wr_addr, wr_data);
endinterface

// File: rtl/imem_loader.sv
// Instruction-memory loader: header byte N, then 4N little-endian data bytes -> N word writes.
// Optional trailing XOR checksum byte when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader #(
  parameter int unsigned DEPTH     = 64,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  imem_loader_if.slave bus,
  output logic         cpu_rst_n,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [7:0]   word_count
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, HDR, DATA, WRITE, CHK, DONE, ERR} state_t;
  localparam state_t LAST_NEXT = CHK;
  logic [7:0] csum;
`else
  typedef enum logic [2:0] {IDLE, HDR, DATA, WRITE, DONE, ERR} state_t;
  localparam state_t LAST_NEXT = DONE;
`endif

  state_t      state, state_d;
  logic [7:0]  nwords;
  logic [1:0]  bidx;
  logic [23:0] asm_q;
  logic        accept, hdr_bad, idle_like;
  logic        ready_d, busy_d, done_d, err_d, wr_en_d;

  assign accept    = bus.byte_valid && bus.byte_ready;
  assign hdr_bad   = (bus.byte_data == 8'h00) || ({24'h0, bus.byte_data} > DEPTH);
  assign idle_like = (state == IDLE) || (state == DONE) || (state == ERR);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_d;

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE, DONE, ERR: if (start) state_d = HDR;
      HDR:   if (accept) state_d = hdr_bad ? ERR : DATA;
      DATA:  if (accept && bidx == 2'd3) state_d = WRITE;
      // word_count already includes the word being strobed
      WRITE: state_d = (word_count == nwords) ? LAST_NEXT : DATA;
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHK:   if (accept) state_d = (bus.byte_data == csum) ? DONE : ERR;
`endif
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered, so they are decoded from the next state.
  always_comb begin
    busy_d  = !((state_d == IDLE) || (state_d == DONE) || (state_d == ERR));
    ready_d = busy_d && (state_d != WRITE);
    wr_en_d = (state_d == WRITE);
    done_d  = (state_d == DONE);
    err_d   = (state_d == ERR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.byte_ready <= 1'b0;
      bus.wr_en      <= 1'b0;
      bus.wr_addr    <= BASE_ADDR;
      bus.wr_data    <= 32'h0;
      cpu_rst_n      <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err            <= 1'b0;
      word_count     <= 8'h0;
      nwords         <= 8'h0;
      bidx           <= 2'd0;
      asm_q          <= 24'h0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum           <= 8'h0;
`endif
    end else begin
      bus.byte_ready <= ready_d;
      bus.wr_en      <= wr_en_d;
      busy           <= busy_d;
      done           <= done_d;
      err            <= err_d;
      cpu_rst_n      <= done_d;
      if (idle_like && start) begin
        word_count <= 8'h0;
        bidx       <= 2'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum       <= 8'h0;
`endif
      end
      if (state == HDR && accept) nwords <= bus.byte_data;
      if (state == DATA && accept) begin
        bidx <= bidx + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum <= csum ^ bus.byte_data;
`endif
        unique case (bidx)
          2'd0: asm_q[7:0]   <= bus.byte_data;
          2'd1: asm_q[15:8]  <= bus.byte_data;
          2'd2: asm_q[23:16] <= bus.byte_data;
          default: begin
            bus.wr_data <= {bus.byte_data, asm_q};
            bus.wr_addr <= BASE_ADDR + {22'h0, word_count, 2'b00};
            word_count  <= word_count + 8'd1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed, table-driven bench for imem_loader (DEPTH=64, BASE_ADDR=0).
module tb_imem_loader;
  localparam int DEPTH = 64;

  logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic       cpu_rst_n, busy, done, err;
  logic [7:0] word_count;

  imem_loader_if ifc ();

  imem_loader #(.DEPTH(DEPTH), .BASE_ADDR(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bus(ifc.slave),
    .cpu_rst_n(cpu_rst_n), .busy(busy), .done(done), .err(err),
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int overlap = 0;
  logic [31:0] wa[$], wd[$];

  always @(negedge clk) begin
    if (ifc.wr_en) begin
      wa.push_back(ifc.wr_addr);
      wd.push_back(ifc.wr_data);
      if (ifc.byte_ready) overlap++;
    end
  end

  typedef struct {
    string           nm;
    int              nb;
    logic [0:9][7:0] b;
    bit              rnd;
    int              nw;
    logic [31:0]     d0, d1;
    logic            dn, er;
    logic [7:0]      cnt;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int tmo = 0;
    ifc.byte_valid = 1'b0;
    repeat (gap) @(negedge clk);
    ifc.byte_valid = 1'b1;
    ifc.byte_data  = b;
    while (!ifc.byte_ready && tmo < 50) begin
      @(negedge clk);
      tmo++;
    end
    if (tmo >= 50) begin
      checks++;
      errors++;
      $display("FAIL send_byte timeout: byte %h never accepted", b);
    end else begin
      @(negedge clk);
    end
    ifc.byte_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk({nm, " idle"}, {31'h0, busy}, 32'h0);
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, " byte_ready"}, {31'h0, ifc.byte_ready}, 32'h0);
    chk({nm, " wr_en"},      {31'h0, ifc.wr_en},      32'h0);
    chk({nm, " wr_addr"},    ifc.wr_addr,             32'h0);
    chk({nm, " wr_data"},    ifc.wr_data,             32'h0);
    chk({nm, " cpu_rst_n"},  {31'h0, cpu_rst_n},      32'h0);
    chk({nm, " busy"},       {31'h0, busy},           32'h0);
    chk({nm, " done"},       {31'h0, done},           32'h0);
    chk({nm, " err"},        {31'h0, err},            32'h0);
    chk({nm, " word_count"}, {24'h0, word_count},     32'h0);
  endtask

  task automatic apply_vec(input vec_t v);
    logic [7:0] x = 8'h00;
    wa.delete();
    wd.delete();
    pulse_start();
    chk({v.nm, " start busy"},  {31'h0, busy},           32'h1);
    chk({v.nm, " start cpu_rst"},{31'h0, cpu_rst_n},     32'h0);
    chk({v.nm, " start ready"}, {31'h0, ifc.byte_ready}, 32'h1);
    chk({v.nm, " start count"}, {24'h0, word_count},     32'h0);
    for (int i = 0; i < v.nb; i++) begin
      send_byte(v.b[i], v.rnd ? int'($urandom_range(0, 3)) : 0);
      if (i > 0) x = x ^ v.b[i];
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (v.dn) send_byte(x, 0);
`else
    if (v.dn) begin
      chk({v.nm, " wr latency"}, {31'h0, ifc.wr_en}, 32'h1);
      @(negedge clk);
      chk({v.nm, " done latency"}, {31'h0, done}, 32'h1);
    end
`endif
    wait_idle(v.nm);
    chk({v.nm, " done"},      {31'h0, done},       {31'h0, v.dn});
    chk({v.nm, " err"},       {31'h0, err},        {31'h0, v.er});
    chk({v.nm, " cpu_rst_n"}, {31'h0, cpu_rst_n},  {31'h0, v.dn});
    chk({v.nm, " count"},     {24'h0, word_count}, {24'h0, v.cnt});
    chk({v.nm, " writes"},    wa.size(),           v.nw);
    if (v.nw >= 1 && wa.size() >= 1) begin
      chk({v.nm, " addr0"}, wa[0], 32'h0);
      chk({v.nm, " data0"}, wd[0], v.d0);
    end
    if (v.nw >= 2 && wa.size() >= 2) begin
      chk({v.nm, " addr1"}, wa[1], 32'h4);
      chk({v.nm, " data1"}, wd[1], v.d1);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{"normal", 9, {8'h02, 8'h13, 8'h01, 8'h50, 8'h00, 8'h93, 8'h01, 8'hC0, 8'h00, 8'h00},
                1'b0, 2, 32'h0050_0113, 32'h00C0_0193, 1'b1, 1'b0, 8'd2};
    vecs[1] = '{"hdr00", 1, {8'h00, 72'h0}, 1'b0, 0, 32'h0, 32'h0, 1'b0, 1'b1, 8'd0};
    vecs[2] = '{"hdr41", 1, {8'h41, 72'h0}, 1'b0, 0, 32'h0, 32'h0, 1'b0, 1'b1, 8'd0};
    vecs[3] = '{"gaps", 9, {8'h02, 8'h13, 8'h01, 8'h50, 8'h00, 8'h93, 8'h01, 8'hC0, 8'h00, 8'h00},
                1'b1, 2, 32'h0050_0113, 32'h00C0_0193, 1'b1, 1'b0, 8'd2};
    vecs[4] = '{"oneword", 5, {8'h01, 8'hB7, 8'h02, 8'h00, 8'h80, 40'h0},
                1'b0, 1, 32'h8000_02B7, 32'h0, 1'b1, 1'b0, 8'd1};

    ifc.byte_valid = 1'b0;
    ifc.byte_data  = 8'h00;
    repeat (2) @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // bytes offered while idle must not be taken
    ifc.byte_valid = 1'b1;
    ifc.byte_data  = 8'h55;
    repeat (3) @(negedge clk);
    chk("idle ready", {31'h0, ifc.byte_ready}, 32'h0);
    chk("idle busy",  {31'h0, busy},           32'h0);
    ifc.byte_valid = 1'b0;

    foreach (vecs[i]) apply_vec(vecs[i]);

    // reset in the middle of the second word
    wa.delete();
    wd.delete();
    pulse_start();
    send_byte(8'h02, 0);
    send_byte(8'h13, 0); send_byte(8'h01, 0); send_byte(8'h50, 0);
    send_byte(8'h00, 0); send_byte(8'h93, 0); send_byte(8'h01, 0);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midreset");
    chk("midreset writes", wa.size(), 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    apply_vec(vecs[4]);

    // start during a load is ignored
    wa.delete();
    wd.delete();
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h13, 0);
    send_byte(8'h01, 0);
    pulse_start();
    chk("ign busy", {31'h0, busy}, 32'h1);
    send_byte(8'h50, 0);
    send_byte(8'h00, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h42, 0);
`endif
    wait_idle("ign");
    chk("ign done",   {31'h0, done}, 32'h1);
    chk("ign writes", wa.size(), 1);
    if (wd.size() >= 1) chk("ign data", wd[0], 32'h0050_0113);
    chk("ign count", {24'h0, word_count}, 32'h1);

    // full-depth load, last word lands at 0xFC
    wa.delete();
    wd.delete();
    pulse_start();
    send_byte(8'h40, 0);
    for (int i = 0; i < 256; i++) send_byte(i[7:0], 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h00, 0);
`endif
    wait_idle("full");
    chk("full done",   {31'h0, done}, 32'h1);
    chk("full count",  {24'h0, word_count}, 32'd64);
    chk("full writes", wa.size(), 64);
    if (wa.size() == 64) begin
      chk("full addr63", wa[63], 32'h0000_00FC);
      chk("full data63", wd[63], 32'hFFFE_FDFC);
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    wa.delete();
    wd.delete();
    pulse_start();
    send_byte(8'h01, 0); send_byte(8'h13, 0); send_byte(8'h01, 0);
    send_byte(8'h50, 0); send_byte(8'h00, 0); send_byte(8'h42, 0);
    wait_idle("csum ok");
    chk("csum ok done", {31'h0, done}, 32'h1);
    wa.delete();
    wd.delete();
    pulse_start();
    send_byte(8'h01, 0); send_byte(8'h13, 0); send_byte(8'h01, 0);
    send_byte(8'h50, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
    wait_idle("csum bad");
    chk("csum bad err",     {31'h0, err},       32'h1);
    chk("csum bad cpu_rst", {31'h0, cpu_rst_n}, 32'h0);
    chk("csum bad writes",  wa.size(),          1);
`endif

    chk("ready during write", overlap, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
